char_box_detect: RTL and testbench
==================================

# char_box_detect

Upstream stage of the digit intersection recognizer. Scans the binarized video stream and finds the bounding box of the character in each frame, rejecting short black noise runs. At each frame end it latches `char_up/down/left/right` and derives the two horizontal scan lines `row_scanf_line1/2`. These outputs are held stable for the whole next frame, where the recognizer consumes them.

## Interface
Parameters:
- MIN_RUN, 3: minimum horizontal black run length (pixels) for a pixel to count as character; legal range 1..15.
- MIN_W, 8: minimum box width (right-left) for a valid box.
- MIN_H, 16: minimum box height (down-up) for a valid box.
- X_MIN, 0 / X_MAX, 479: inclusive region-of-interest column limits.
- Y_MIN, 0 / Y_MAX, 271: inclusive region-of-interest row limits.

Ports:
- clk, in, 1: pixel clock; the only clock.
- rst_n, in, 1: asynchronous, active-low reset.
- x, in, 12: current pixel column.
- y, in, 12: current pixel row.
- i_vs, in, 1: frame active, high during the frame.
- i_de, in, 1: pixel valid.
- i_th, in, 1: binarized pixel; 0 is black (character), 1 is white.
- char_up, char_down, char_left, char_right, out, 12 each: registered bounding box of the last valid frame.
- row_scanf_line1, row_scanf_line2, out, 12 each: registered scan rows of the last valid frame.
- box_valid, out, 1: the last completed frame produced a valid box.
- frame_done, out, 1: one-cycle pulse when the frame-end update completes.

## Operation
- **States:** IDLE, ACCUM, LATCH, CALC.
  - IDLE → ACCUM: on i_vs rising edge. The edge is detected against a registered copy vs_d0.
  - ACCUM → LATCH: on i_vs falling edge (vs_d0 = 1, i_vs = 0).
  - LATCH → CALC: unconditional.
  - CALC → IDLE: unconditional.
- **ACCUM, run qualification:** a pixel is in-ROI when i_de = 1, X_MIN ≤ x ≤ X_MAX and Y_MIN ≤ y ≤ Y_MAX.
  - run_cnt, 4 bits, saturates at MIN_RUN.
  - run_cnt is cleared by any non-in-ROI cycle or by i_th = 1.
  - run_cnt increments on an in-ROI black pixel.
- **ACCUM, qualifying pixel:** an in-ROI black pixel with run_cnt ≥ MIN_RUN-1 before the increment.
  - On the first qualifying pixel of a run, update with start column x-(MIN_RUN-1) and end column x.
  - On subsequent qualifying pixels, update with end column x only.
  - Update rules: min_x ← min(min_x, start), max_x ← max(max_x, x), min_y ← min(min_y, y), max_y ← max(max_y, y), hit ← 1.
- **Entering ACCUM:** min_x/min_y are set to 12'hFFF, max_x/max_y to 0, hit to 0 and run_cnt to 0.
- **LATCH:** a frame is valid when hit = 1, (max_x-min_x) ≥ MIN_W and (max_y-min_y) ≥ MIN_H.
  - If valid: char_left/right/up/down ← min_x/max_x/min_y/max_y, and h ← max_y-min_y is registered.
  - box_valid ← valid.
  - If invalid: box and line outputs hold their previous values.
- **CALC** (only updates lines if LATCH was valid):
  - row_scanf_line1 ← char_up + ((h·5)>>4).
  - row_scanf_line2 ← char_up + ((h·11)>>4).
  - Products use 16-bit unsigned intermediates and are truncated to 12 bits after the add.
  - frame_done = 1 for this cycle regardless of validity.
- **Reset values:** all outputs 0, state IDLE, vs_d0 0, run_cnt 0.

## Timing
- **Edge latency:** i_vs falls at cycle F (first cycle with i_vs = 0). Then vs_d0 = 1 at F, so the FSM is in LATCH at F+1 and CALC at F+2.
- **Output latency:**
  - Box outputs and box_valid change at the F+2 edge.
  - Line outputs change and frame_done is high in the cycle after that.
  - All outputs are stable at F+3 and held until the next frame end.
- **Pixel sampling:** pixels are sampled on the same edge they are presented; there is no input pipeline. The pixel coincident with the i_vs fall is ignored.
- **Short vblank:** an i_vs rising edge seen while in LATCH or CALC is lost. The FSM returns to IDLE, and that frame is skipped with outputs unchanged. Minimum vblank for continuous operation is 3 cycles.
- **Reset mid-frame:** the FSM is in IDLE with i_vs high. No update occurs at the next i_vs fall; the first full frame after reset updates.
- **Back-to-back runs:** a white pixel between two runs resets run_cnt, so each run must independently reach MIN_RUN.

## Test plan
- **Clean rectangle:** black rectangle x 100..149, y 50..149, rest white, defaults → at F+3:
  - left 100, right 149, up 50, down 149;
  - line1 80, line2 118;
  - box_valid 1; frame_done 1 for one cycle.
- **Noise rejection:** same rectangle plus 2-pixel black runs at (10..11, 10) and (400..401, 250) → identical outputs to the clean-rectangle case.
- **Invalid frames, outputs hold:**
  - All-white frame after the clean-rectangle frame → box_valid 0, frame_done pulses, box and lines keep 100/149/50/149/80/118.
  - Rectangle 5 wide (x 200..204, y 50..149) → box_valid 0, outputs held.
- **ROI boundary:** X_MAX 479, black run x 478..479 followed by i_de low, then black x 0..1 on the next row → no qualification (hit 0, box_valid 0).
- **Reset mid-frame:** rst_n pulsed low at y 100 during the rectangle frame → all outputs 0 during reset and no update at that frame's end. The next rectangle frame yields the clean-rectangle outputs.
- **Short vblank:** i_vs low for 1 cycle between frames → the second frame is skipped (no frame_done at its end); the third frame updates normally.

Source files
------------

// File: rtl/char_box_detect.sv
// Per-frame character bounding box finder: qualifies horizontal black runs,
// tracks their extent during the frame and latches box plus scan rows at frame end.
module char_box_detect #(
    parameter int MIN_RUN = 3,
    parameter int MIN_W   = 8,
    parameter int MIN_H   = 16,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 479,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 271
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic        i_th,
    output logic [11:0] char_up,
    output logic [11:0] char_down,
    output logic [11:0] char_left,
    output logic [11:0] char_right,
    output logic [11:0] row_scanf_line1,
    output logic [11:0] row_scanf_line2,
    output logic        box_valid,
    output logic        frame_done
);
    typedef enum logic [1:0] {IDLE, ACCUM, LATCH, CALC} state_t;

    localparam logic [3:0]  RUN_SAT   = 4'(MIN_RUN);
    localparam logic [3:0]  RUN_M1    = 4'(MIN_RUN - 1);
    localparam logic [11:0] START_OFF = 12'(MIN_RUN - 1);

    state_t      state, state_nxt;
    logic        vs_d0, armed;
    logic        vs_rise, vs_fall;
    logic [3:0]  run_cnt;
    logic [11:0] min_x, max_x, min_y, max_y;
    logic        hit;
    logic [11:0] h;
    logic        latch_ok;
    int          xi, yi;
    logic        in_roi, black, qual, first;
    logic [11:0] start_x;
    logic [11:0] box_w, box_h;
    logic        frame_ok;
    logic [15:0] prod5, prod11, sum1, sum2;

    // A frame already in progress at reset release must end before a rise is trusted.
    assign vs_rise = i_vs & ~vs_d0 & armed;
    assign vs_fall = ~i_vs & vs_d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0 <= 1'b0;
            armed <= 1'b0;
            state <= IDLE;
        end else begin
            vs_d0 <= i_vs;
            armed <= armed | ~i_vs;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = ACCUM;
            ACCUM:   if (vs_fall) state_nxt = LATCH;
            LATCH:   state_nxt = CALC;
            CALC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign xi     = int'(x);
    assign yi     = int'(y);
    assign in_roi = i_de && (xi >= X_MIN) && (xi <= X_MAX) && (yi >= Y_MIN) && (yi <= Y_MAX);
    // The pixel coincident with the i_vs fall is not part of the frame.
    assign black   = (state == ACCUM) && i_vs && in_roi && !i_th;
    assign qual    = black && (run_cnt >= RUN_M1);
    assign first   = qual && (run_cnt == RUN_M1);
    assign start_x = first ? (x - START_OFF) : x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            min_x   <= 12'hFFF;
            min_y   <= 12'hFFF;
            max_x   <= '0;
            max_y   <= '0;
            hit     <= 1'b0;
        end else if (state == IDLE && vs_rise) begin
            run_cnt <= '0;
            min_x   <= 12'hFFF;
            min_y   <= 12'hFFF;
            max_x   <= '0;
            max_y   <= '0;
            hit     <= 1'b0;
        end else if (state == ACCUM) begin
            if (black) run_cnt <= (run_cnt == RUN_SAT) ? run_cnt : run_cnt + 4'd1;
            else       run_cnt <= '0;
            if (qual) begin
                if (start_x < min_x) min_x <= start_x;
                if (x > max_x)       max_x <= x;
                if (y < min_y)       min_y <= y;
                if (y > max_y)       max_y <= y;
                hit <= 1'b1;
            end
        end
    end

    assign box_w    = max_x - min_x;
    assign box_h    = max_y - min_y;
    assign frame_ok = hit && (box_w >= 12'(MIN_W)) && (box_h >= 12'(MIN_H));

    assign prod5  = 16'(h) * 16'd5;
    assign prod11 = 16'(h) * 16'd11;
    assign sum1   = 16'(char_up) + (prod5 >> 4);
    assign sum2   = 16'(char_up) + (prod11 >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_up         <= '0;
            char_down       <= '0;
            char_left       <= '0;
            char_right      <= '0;
            row_scanf_line1 <= '0;
            row_scanf_line2 <= '0;
            box_valid       <= 1'b0;
            frame_done      <= 1'b0;
            h               <= '0;
            latch_ok        <= 1'b0;
        end else begin
            frame_done <= (state == CALC);
            if (state == LATCH) begin
                box_valid <= frame_ok;
                latch_ok  <= frame_ok;
                if (frame_ok) begin
                    char_left  <= min_x;
                    char_right <= max_x;
                    char_up    <= min_y;
                    char_down  <= max_y;
                    h          <= box_h;
                end
            end
            if (state == CALC && latch_ok) begin
                row_scanf_line1 <= sum1[11:0];
                row_scanf_line2 <= sum2[11:0];
            end
        end
    end
endmodule

// File: tb/tb_char_box_detect.sv
// Directed and randomized frames against a run-level reference of the box detector.
module tb_char_box_detect;
    localparam int MIN_RUN = 3, MIN_W = 8, MIN_H = 16;
    localparam int X_MIN = 0, X_MAX = 479, Y_MIN = 0, Y_MAX = 271;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] x = '0, y = '0;
    logic        i_vs = 1'b0, i_de = 1'b0, i_th = 1'b1;
    logic [11:0] char_up, char_down, char_left, char_right;
    logic [11:0] row_scanf_line1, row_scanf_line2;
    logic        box_valid, frame_done;

    always #5 clk = ~clk;

    char_box_detect #(
        .MIN_RUN(MIN_RUN), .MIN_W(MIN_W), .MIN_H(MIN_H),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .i_vs(i_vs), .i_de(i_de), .i_th(i_th),
        .char_up(char_up), .char_down(char_down),
        .char_left(char_left), .char_right(char_right),
        .row_scanf_line1(row_scanf_line1), .row_scanf_line2(row_scanf_line2),
        .box_valid(box_valid), .frame_done(frame_done)
    );

    typedef struct { int x0; int x1; int y0; int y1; } rect_t;
    typedef struct { int y; int xa; int xb; } seg_t;

    rect_t img[$];
    seg_t  segs[$];
    int    checks = 0, errors = 0;
    int    e_up = 0, e_down = 0, e_left = 0, e_right = 0, e_l1 = 0, e_l2 = 0, e_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_up"}, 32'(char_up), e_up);
        chk({tag, "_down"}, 32'(char_down), e_down);
        chk({tag, "_left"}, 32'(char_left), e_left);
        chk({tag, "_right"}, 32'(char_right), e_right);
        chk({tag, "_line1"}, 32'(row_scanf_line1), e_l1);
        chk({tag, "_line2"}, 32'(row_scanf_line2), e_l2);
        chk({tag, "_valid"}, 32'(box_valid), e_valid);
    endtask

    function automatic bit is_black(int px, int py);
        foreach (img[i])
            if (px >= img[i].x0 && px <= img[i].x1 && py >= img[i].y0 && py <= img[i].y1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_roi(int px, int py);
        return px >= X_MIN && px <= X_MAX && py >= Y_MIN && py <= Y_MAX;
    endfunction

    // Box = extent of every maximal in-ROI black run of length >= MIN_RUN inside one segment.
    task automatic apply_frame();
        int l, r, u, d, rs, hh;
        bit hit, b;
        l = 4095; r = 0; u = 4095; d = 0; hit = 1'b0;
        foreach (segs[k]) begin
            rs = -1;
            for (int px = segs[k].xa; px <= segs[k].xb + 1; px++) begin
                b = (px <= segs[k].xb) && in_roi(px, segs[k].y) && is_black(px, segs[k].y);
                if (b && rs < 0) rs = px;
                else if (!b && rs >= 0) begin
                    if (px - rs >= MIN_RUN) begin
                        hit = 1'b1;
                        if (rs < l) l = rs;
                        if (px - 1 > r) r = px - 1;
                        if (segs[k].y < u) u = segs[k].y;
                        if (segs[k].y > d) d = segs[k].y;
                    end
                    rs = -1;
                end
            end
        end
        e_valid = int'(hit && (r - l) >= MIN_W && (d - u) >= MIN_H);
        if (e_valid == 1) begin
            hh = d - u;
            e_left = l; e_right = r; e_up = u; e_down = d;
            e_l1 = (u + (hh * 5) / 16) % 4096;
            e_l2 = (u + (hh * 11) / 16) % 4096;
        end
    endtask

    task automatic drive_body(input int rst_row);
        foreach (segs[k]) begin
            if (segs[k].y == rst_row) begin
                @(negedge clk); rst_n = 1'b0; i_de = 1'b0; #1;
                e_up = 0; e_down = 0; e_left = 0; e_right = 0; e_l1 = 0; e_l2 = 0; e_valid = 0;
                chk("rst_fd", 32'(frame_done), 0);
                chk_all("in_reset");
                @(negedge clk); rst_n = 1'b1;
            end
            for (int px = segs[k].xa; px <= segs[k].xb; px++) begin
                @(negedge clk);
                x = 12'(px); y = 12'(segs[k].y); i_de = 1'b1;
                i_th = !is_black(px, segs[k].y);
            end
            @(negedge clk); i_de = 1'b0; i_th = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic drive_frame(input int rst_row);
        @(negedge clk); i_vs = 1'b1; i_de = 1'b0;
        @(negedge clk);
        drive_body(rst_row);
    endtask

    task automatic end_frame(input bit upd);
        int old_l1;
        old_l1 = e_l1;
        @(negedge clk); i_vs = 1'b0; i_de = 1'b0;
        if (upd) apply_frame();
        @(posedge clk); @(posedge clk); #1;
        chk("fd_early", 32'(frame_done), 0);
        chk("valid_p2", 32'(box_valid), e_valid);
        chk("left_p2", 32'(char_left), e_left);
        chk("line1_p2", 32'(row_scanf_line1), old_l1);
        @(posedge clk); #1;
        chk("frame_done", 32'(frame_done), 32'(upd));
        chk_all("frame");
        @(posedge clk); #1;
        chk("fd_pulse", 32'(frame_done), 0);
    endtask

    task automatic rect_frame(input int x0, input int x1, input int wx0, input int wx1);
        img.delete(); segs.delete();
        img.push_back('{x0, x1, 50, 149});
        for (int r = 48; r <= 151; r++) segs.push_back('{r, wx0, wx1});
    endtask

    task automatic small_window(input int n);
        segs.delete();
        for (int r = 0; r < n; r++) segs.push_back('{r, 0, n - 1});
    endtask

    task automatic chk_clean(input string tag);
        chk({tag, "_left"}, 32'(char_left), 100);
        chk({tag, "_right"}, 32'(char_right), 149);
        chk({tag, "_up"}, 32'(char_up), 50);
        chk({tag, "_down"}, 32'(char_down), 149);
        chk({tag, "_line1"}, 32'(row_scanf_line1), 80);
        chk({tag, "_line2"}, 32'(row_scanf_line2), 118);
    endtask

    initial begin
        int x0, y0, n;
        repeat (3) @(negedge clk);
        #1;
        chk_all("reset");
        chk("reset_fd", 32'(frame_done), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // clean rectangle
        rect_frame(100, 149, 97, 152);
        drive_frame(-1); end_frame(1'b1);
        chk_clean("clean");
        chk("clean_valid", 32'(box_valid), 1);

        // all-white frame holds box
        img.delete(); small_window(20);
        drive_frame(-1); end_frame(1'b1);
        chk_clean("white_hold");
        chk("white_valid", 32'(box_valid), 0);

        // 5-wide rectangle is rejected
        rect_frame(200, 204, 197, 207);
        drive_frame(-1); end_frame(1'b1);
        chk_clean("narrow_hold");

        // rectangle plus 2-pixel noise runs
        rect_frame(100, 149, 97, 152);
        img.push_back('{10, 11, 10, 10});
        img.push_back('{400, 401, 250, 250});
        segs.push_front('{10, 5, 15});
        segs.push_back('{250, 395, 405});
        drive_frame(-1); end_frame(1'b1);
        chk_clean("noise");

        // ROI right edge: only 2 in-ROI black pixels, then wrap to next row
        img.delete(); segs.delete();
        img.push_back('{478, 481, 10, 10});
        img.push_back('{0, 1, 11, 11});
        segs.push_back('{10, 470, 481});
        segs.push_back('{11, 0, 5});
        drive_frame(-1); end_frame(1'b1);
        chk("roi_valid", 32'(box_valid), 0);
        chk_clean("roi_hold");

        // reset mid-frame, then a full frame
        rect_frame(100, 149, 97, 152);
        drive_frame(100); end_frame(1'b0);
        rect_frame(100, 149, 97, 152);
        drive_frame(-1); end_frame(1'b1);
        chk_clean("after_rst");

        // short vblank: A updates, B is lost, C updates
        img.delete(); img.push_back('{5, 20, 2, 25}); small_window(30);
        drive_frame(-1);
        @(negedge clk); i_vs = 1'b0; i_de = 1'b0;
        apply_frame();
        @(negedge clk); i_vs = 1'b1;
        @(posedge clk); #1;
        chk("sv_fd_early", 32'(frame_done), 0);
        @(posedge clk); #1;
        chk("sv_fd", 32'(frame_done), 1);
        chk_all("sv_a");
        @(posedge clk); #1;
        chk("sv_fd_pulse", 32'(frame_done), 0);
        img.delete(); img.push_back('{10, 28, 0, 20});
        drive_body(-1); end_frame(1'b0);
        img.delete(); img.push_back('{0, 12, 5, 29});
        drive_frame(-1); end_frame(1'b1);
        chk("sv_c_left", 32'(char_left), 0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            img.delete();
            n = int'($urandom_range(1, 2));
            for (int i = 0; i < n; i++) begin
                x0 = int'($urandom_range(0, 30)); y0 = int'($urandom_range(0, 20));
                img.push_back('{x0, x0 + int'($urandom_range(0, 12)), y0, y0 + int'($urandom_range(0, 20))});
            end
            for (int i = 0; i < 2; i++) begin
                x0 = int'($urandom_range(0, 38)); y0 = int'($urandom_range(0, 39));
                img.push_back('{x0, x0 + int'($urandom_range(0, 1)), y0, y0});
            end
            small_window(40);
            drive_frame(-1); end_frame(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
